// File: rtl/uart_rx.sv
// uart_rx: serial receiver for 8 data bits, one parity bit and 1 or 2 stop
// bits, LSB first. The line is sampled at bit centres. Each received byte
// lands in a one-entry holding register that the consumer pops with rd_en.
module uart_rx #(
  parameter int BAUD_DIVISOR = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Rx_in,
  input  logic       Rx_en,
  input  logic       Two_stop,
  input  logic       Odd_parity,
  input  logic       rd_en,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun
);

  // Count values at which the line is sampled: half a bit into the start bit,
  // then one full bit period per sample after that.
  localparam logic [13:0] FULL_M1 = 14'(BAUD_DIVISOR - 1);
  localparam logic [13:0] HALF_M1 = 14'(BAUD_DIVISOR / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP1,
    S_STOP2
  } state_e;

  // Synchroniser.
  logic sync1_q, sync2_q;
  logic rx_s;

  // Frame receiver.
  state_e      state_q, state_d;
  logic [13:0] cnt_q, cnt_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        two_stop_q, two_stop_d;
  logic        odd_q, odd_d;
  logic        perr_q, perr_d;
  logic        ferr_q, ferr_d;
  logic        done_q, done_d;
  logic        armed_q, armed_d;

  // Holding register.
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        parity_err_q, parity_err_d;
  logic        frame_err_q, frame_err_d;
  logic        overrun_q, overrun_d;

  logic at_centre;

  assign rx_s      = sync2_q;
  assign at_centre = (cnt_q == FULL_M1);

  // Two-flop synchroniser. It resets to the idle line level so that reset
  // does not manufacture a falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= Rx_in;
      sync2_q <= sync1_q;
    end
  end

  // Receiver state and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      two_stop_q <= 1'b0;
      odd_q      <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      done_q     <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      two_stop_q <= two_stop_d;
      odd_q      <= odd_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      done_q     <= done_d;
      armed_q    <= armed_d;
    end
  end

  // The armed flag re-arms on any high line level and drops at frame
  // completion. A line held low (break) therefore yields one frame only.
  always_comb begin
    armed_d = rx_s | (armed_q & ~done_q);
  end

  // Next-state logic. Every state transition, including a DATA self-loop
  // after a sample, reloads the baud counter to 0.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 14'd1;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    two_stop_d = two_stop_q;
    odd_d      = odd_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        // Start detection is held off during the completion cycle so that
        // a new frame cannot begin before the holding register settles.
        if (Rx_en && !rx_s && armed_q && !done_q) begin
          state_d    = S_START;
          two_stop_d = Two_stop;
          odd_d      = Odd_parity;
          bit_cnt_d  = '0;
          perr_d     = 1'b0;
          ferr_d     = 1'b0;
        end
      end

      S_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          state_d = rx_s ? S_IDLE : S_DATA;
        end
      end

      S_DATA: begin
        if (at_centre) begin
          cnt_d     = '0;
          shift_d   = {rx_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) state_d = S_PARITY;
        end
      end

      S_PARITY: begin
        if (at_centre) begin
          cnt_d   = '0;
          perr_d  = ((^shift_q) ^ rx_s) != odd_q;
          state_d = S_STOP1;
        end
      end

      S_STOP1: begin
        if (at_centre) begin
          cnt_d  = '0;
          ferr_d = ~rx_s;
          if (two_stop_q) begin
            state_d = S_STOP2;
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end

      S_STOP2: begin
        if (at_centre) begin
          cnt_d   = '0;
          ferr_d  = ferr_q | ~rx_s;
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Holding register. A finished frame loads it when the register is empty
  // or is being read in the same cycle; otherwise the frame is dropped and
  // overrun latches. Bytes with errors are delivered together with their flags.
  always_comb begin
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    overrun_d    = overrun_q;

    if (done_q) begin
      if (!rx_valid_q || rd_en) begin
        rx_data_d    = shift_q;
        rx_valid_d   = 1'b1;
        parity_err_d = perr_q;
        frame_err_d  = ferr_q;
        overrun_d    = 1'b0;
      end else begin
        overrun_d    = 1'b1;
      end
    end else if (rd_en && rx_valid_q) begin
      rx_valid_d   = 1'b0;
      parity_err_d = 1'b0;
      frame_err_d  = 1'b0;
      overrun_d    = 1'b0;
    end
  end

  // Holding register state.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx at BAUD_DIVISOR=16. Frames are driven bit by bit on
// Rx_in. Results are compared against a small model of the holding register.
module tb_uart_rx;
  localparam int BD = 16;

  logic       clk = 1'b0;
  logic       rst, Rx_in, Rx_en, Two_stop, Odd_parity, rd_en;
  logic [7:0] rx_data;
  logic       rx_valid, parity_err, frame_err, overrun;

  int checks = 0;
  int errors = 0;

  // Model of the holding register: {valid, data, perr, ferr, ovr}.
  logic       m_valid, m_perr, m_ferr, m_ovr;
  logic [7:0] m_data;

  uart_rx #(.BAUD_DIVISOR(BD)) dut (
    .clk(clk), .rst(rst), .Rx_in(Rx_in), .Rx_en(Rx_en), .Two_stop(Two_stop),
    .Odd_parity(Odd_parity), .rd_en(rd_en), .rx_data(rx_data),
    .rx_valid(rx_valid), .parity_err(parity_err), .frame_err(frame_err),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] obs();
    return {rx_valid, rx_data, parity_err, frame_err, overrun};
  endfunction

  function automatic logic [11:0] model_vec();
    return {m_valid, m_data, m_perr, m_ferr, m_ovr};
  endfunction

  // Parity bit that makes the frame correct for the chosen mode.
  function automatic logic good_par(input logic [7:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

  task automatic model_clear();
    m_valid = 0; m_data = 0; m_perr = 0; m_ferr = 0; m_ovr = 0;
  endtask

  task automatic model_frame(input logic [7:0] d, input logic par, input logic odd,
                             input logic s1, input logic two, input logic s2);
    if (!m_valid) begin
      m_valid = 1;
      m_data  = d;
      m_perr  = ((^d) ^ par) != odd;
      m_ferr  = !s1 || (two && !s2);
    end else begin
      m_ovr = 1;
    end
  endtask

  task automatic model_pop();
    if (m_valid) begin
      m_valid = 0; m_perr = 0; m_ferr = 0; m_ovr = 0;
    end
  endtask

  task automatic idle(input int n);
    Rx_in = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pop();
    @(posedge clk); #1 rd_en = 1'b1;
    @(posedge clk); #1 rd_en = 1'b0;
  endtask

  // Drive one frame. rd_at pulses rd_en after that cycle index. cut_at stops
  // driving early and leaves the line at its current level. Use -1 to disable either.
  task automatic send_frame(input logic [7:0] d, input logic par, input int nstop,
                            input logic s1, input logic s2, input int rd_at,
                            input int cut_at);
    logic [11:0] bits;
    int nbits;
    nbits = 10 + nstop;
    bits = {s2, s1, par, d, 1'b0};
    for (int c = 0; c < nbits * BD; c++) begin
      if (c == cut_at) break;
      @(posedge clk); #1;
      Rx_in = bits[c / BD];
      rd_en = (c == rd_at);
    end
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1; Rx_in = 1; Rx_en = 1; Two_stop = 0; Odd_parity = 0; rd_en = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (obs() !== 12'h000) begin
      errors++; $display("FAIL reset: got %h want %h", obs(), 12'h000);
    end
    rst = 0;
    model_clear();
    idle(4);
  endtask

  task automatic test_even_1stop();
    Two_stop = 0; Odd_parity = 0;
    send_frame(8'hA5, 1'b0, 1, 1'b1, 1'b1, -1, -1);
    checks++;
    if (obs() !== {1'b1, 8'hA5, 3'b000}) begin
      errors++; $display("FAIL even_1stop: got %h want %h", obs(), {1'b1, 8'hA5, 3'b000});
    end
    pop();
    checks++;
    if (obs() !== {1'b0, 8'hA5, 3'b000}) begin
      errors++; $display("FAIL even_1stop_pop: got %h want %h", obs(), {1'b0, 8'hA5, 3'b000});
    end
    pop();  // read while empty has no effect
    checks++;
    if (obs() !== {1'b0, 8'hA5, 3'b000}) begin
      errors++; $display("FAIL empty_read: got %h want %h", obs(), {1'b0, 8'hA5, 3'b000});
    end
    idle(BD);
  endtask

  task automatic test_odd_2stop();
    Two_stop = 1; Odd_parity = 1;
    send_frame(8'h3C, 1'b1, 2, 1'b1, 1'b1, -1, -1);
    checks++;
    if (obs() !== {1'b1, 8'h3C, 3'b000}) begin
      errors++; $display("FAIL odd_2stop: got %h want %h", obs(), {1'b1, 8'h3C, 3'b000});
    end
    pop();
    send_frame(8'h3C, 1'b1, 2, 1'b1, 1'b0, -1, -1);
    checks++;
    if (obs() !== {1'b1, 8'h3C, 3'b010}) begin
      errors++; $display("FAIL odd_2stop_ferr: got %h want %h", obs(), {1'b1, 8'h3C, 3'b010});
    end
    pop();
    idle(2 * BD);
  endtask

  task automatic test_parity_err();
    logic [7:0] td [3] = '{8'h01, 8'h01, 8'h01};
    logic       tp [3] = '{1'b1, 1'b0, 1'b0};
    logic       to [3] = '{1'b1, 1'b1, 1'b0};
    logic       te [3] = '{1'b1, 1'b0, 1'b1};
    Two_stop = 0;
    for (int i = 0; i < 3; i++) begin
      Odd_parity = to[i];
      send_frame(td[i], tp[i], 1, 1'b1, 1'b1, -1, -1);
      checks++;
      if (obs() !== {1'b1, td[i], te[i], 2'b00}) begin
        errors++;
        $display("FAIL parity_%0d: got %h want %h", i, obs(), {1'b1, td[i], te[i], 2'b00});
      end
      pop();
      idle(BD);
    end
  endtask

  task automatic test_glitch_break();
    Two_stop = 0; Odd_parity = 0;
    Rx_in = 0;
    repeat (5) @(posedge clk);
    #1;
    idle(3 * BD);
    checks++;
    if (rx_valid !== 1'b0) begin
      errors++; $display("FAIL glitch: got rx_valid=%0b want 0", rx_valid);
    end
    send_frame(8'h96, 1'b0, 1, 1'b1, 1'b1, -1, -1);
    checks++;
    if (obs() !== {1'b1, 8'h96, 3'b000}) begin
      errors++; $display("FAIL after_glitch: got %h want %h", obs(), {1'b1, 8'h96, 3'b000});
    end
    pop();
    idle(BD);
    // Break: 40 bit times low yields one all-zero frame with a framing error.
    // A second frame would show up as overrun.
    Rx_in = 0;
    repeat (40 * BD) @(posedge clk);
    #1;
    checks++;
    if (obs() !== {1'b1, 8'h00, 3'b010}) begin
      errors++; $display("FAIL break: got %h want %h", obs(), {1'b1, 8'h00, 3'b010});
    end
    idle(4);
    pop();
    idle(3 * BD);
    checks++;
    if (obs() !== {1'b0, 8'h00, 3'b000}) begin
      errors++; $display("FAIL break_release: got %h want %h", obs(), {1'b0, 8'h00, 3'b000});
    end
  endtask

  task automatic test_overrun();
    Two_stop = 0; Odd_parity = 0;
    send_frame(8'h11, 1'b0, 1, 1'b1, 1'b1, -1, -1);
    send_frame(8'h22, 1'b0, 1, 1'b1, 1'b1, -1, -1);
    checks++;
    if (obs() !== {1'b1, 8'h11, 3'b001}) begin
      errors++; $display("FAIL overrun: got %h want %h", obs(), {1'b1, 8'h11, 3'b001});
    end
    pop();
    checks++;
    if (obs() !== {1'b0, 8'h11, 3'b000}) begin
      errors++; $display("FAIL overrun_clear: got %h want %h", obs(), {1'b0, 8'h11, 3'b000});
    end
    idle(BD);
    // Read in the completion cycle of the second frame. The completion cycle
    // follows the last stop-bit centre: 3 cycles for sync and detect, half a
    // bit into the start bit, then 9+nstop further bit periods.
    send_frame(8'h11, 1'b0, 1, 1'b1, 1'b1, -1, -1);
    send_frame(8'h22, 1'b0, 1, 1'b1, 1'b1, 3 + BD / 2 + BD * 10, -1);
    checks++;
    if (obs() !== {1'b1, 8'h22, 3'b000}) begin
      errors++; $display("FAIL read_on_complete: got %h want %h", obs(), {1'b1, 8'h22, 3'b000});
    end
    pop();
    idle(BD);
  endtask

  task automatic test_reset_midframe();
    Two_stop = 0; Odd_parity = 0;
    send_frame(8'h33, 1'b0, 1, 1'b1, 1'b1, -1, -1);
    send_frame(8'h77, 1'b0, 1, 1'b1, 1'b1, -1, BD * 5 + BD / 2);
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1;
    checks++;
    if (obs() !== 12'h000) begin
      errors++; $display("FAIL reset_mid: got %h want %h", obs(), 12'h000);
    end
    rst = 0;
    idle(3 * BD);
    checks++;
    if (obs() !== 12'h000) begin
      errors++; $display("FAIL reset_no_partial: got %h want %h", obs(), 12'h000);
    end
    send_frame(8'h5A, 1'b0, 1, 1'b1, 1'b1, -1, -1);
    checks++;
    if (obs() !== {1'b1, 8'h5A, 3'b000}) begin
      errors++; $display("FAIL reset_recover: got %h want %h", obs(), {1'b1, 8'h5A, 3'b000});
    end
    pop();
    idle(BD);
  endtask

  task automatic test_rx_disabled();
    Rx_en = 0;
    send_frame(8'hC3, 1'b0, 1, 1'b1, 1'b1, -1, -1);
    idle(BD);
    checks++;
    if (rx_valid !== 1'b0) begin
      errors++; $display("FAIL rx_disabled: got rx_valid=%0b want 0", rx_valid);
    end
    Rx_en = 1;
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic odd, two, par, s1, s2;
    model_clear();
    for (int i = 0; i < 14; i++) begin
      d   = 8'($urandom);
      odd = 1'($urandom_range(0, 1));
      two = 1'($urandom_range(0, 1));
      par = good_par(d, odd) ^ ($urandom_range(0, 3) == 0);
      s1  = ($urandom_range(0, 4) != 0);
      s2  = two ? ($urandom_range(0, 4) != 0) : 1'b1;
      Two_stop = two; Odd_parity = odd;
      send_frame(d, par, two ? 2 : 1, s1, s2, -1, -1);
      model_frame(d, par, odd, s1, two, s2);
      checks++;
      if (obs() !== model_vec()) begin
        errors++; $display("FAIL random_%0d: got %h want %h", i, obs(), model_vec());
      end
      if ($urandom_range(0, 2) != 0) begin
        pop();
        model_pop();
        checks++;
        if (obs() !== model_vec()) begin
          errors++; $display("FAIL random_pop_%0d: got %h want %h", i, obs(), model_vec());
        end
      end
      idle(2 * BD);
    end
  endtask

  initial begin
    test_reset();
    test_even_1stop();
    test_odd_2stop();
    test_parity_err();
    test_glitch_break();
    test_overrun();
    test_reset_midframe();
    test_rx_disabled();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
